// File: rtl/demux_1_4_stream_pkg.sv
// Shared definitions for the 1-to-N stream demultiplexer: default widths, sink
// index names and the per-slot state encoding.
package demux_1_4_stream_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_SEL_W  = 2;
  localparam int DEF_CNT_W  = 16;

  // Sink numbering as wired in the core: tape RAM first, then the output port.
  localparam int SINK_TAPE = 0;
  localparam int SINK_OUT  = 1;
  localparam int SINK_AUX0 = 2;
  localparam int SINK_AUX1 = 3;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  function automatic int num_out(input int sel_w);
    return 1 << sel_w;
  endfunction

  localparam int DEF_NUM_OUT = num_out(DEF_SEL_W);

endpackage

// File: rtl/demux_1_4_stream_if.sv
// Stream bundle for the demultiplexer: one valid/ready source side and
// NUM_OUT valid/ready sink sides.
interface demux_1_4_stream_if
  import demux_1_4_stream_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int SEL_W  = DEF_SEL_W
);

  localparam int NUM_OUT = num_out(SEL_W);

  logic                      s_valid;
  logic                      s_ready;
  logic [DATA_W-1:0]         s_data;
  logic [SEL_W-1:0]          s_sel;
  logic [NUM_OUT-1:0]        m_valid;
  logic [NUM_OUT-1:0]        m_ready;
  logic [NUM_OUT*DATA_W-1:0] m_data;

  // The demultiplexer itself takes the slave view; the surrounding source and
  // sinks together take the master view.
  modport slave (
    input  s_valid, s_data, s_sel, m_ready,
    output s_ready, m_valid, m_data
  );

  modport master (
    output s_valid, s_data, s_sel, m_ready,
    input  s_ready, m_valid, m_data
  );

endinterface

// File: rtl/demux_1_4_stream_slot.sv
// One-entry holding register for a single sink: loads on accept, empties on
// drain, and reloads in place when both happen in the same cycle.
module demux_slot
  import demux_1_4_stream_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] dout
);

  slot_state_t       state;
  slot_state_t       state_nxt;
  logic [DATA_W-1:0] data_q;
  logic              drain;

  assign drain = (state == SLOT_FULL) && ready;

  // Data is never cleared on drain; only the valid bit tells the sink it is fresh.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= SLOT_EMPTY;
      data_q <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        data_q <= din;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SLOT_EMPTY: if (load) state_nxt = SLOT_FULL;
      SLOT_FULL:  if (drain && !load) state_nxt = SLOT_EMPTY;
      default:    state_nxt = SLOT_EMPTY;
    endcase
  end

  assign valid = (state == SLOT_FULL);
  assign dout  = data_q;

endmodule

// File: rtl/demux_1_4_stream.sv
// Registered 1-to-NUM_OUT demultiplexer for a valid/ready word stream, with a
// free-running count of accepted words for debug.
module demux_1_4_stream
  import demux_1_4_stream_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int SEL_W  = DEF_SEL_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  demux_1_4_stream_if.slave     bus,
  output logic [CNT_W-1:0]      acc_cnt
);

  localparam int NUM_OUT = num_out(SEL_W);

  logic [NUM_OUT-1:0]        m_valid_w;
  logic [NUM_OUT*DATA_W-1:0] m_data_w;
  logic                      s_ready_w;
  logic                      accept;

  // Only the selected sink can block the source; a full slot frees up in the
  // same cycle its sink takes the word, giving one word per cycle per sink.
  assign s_ready_w = !rst && (!m_valid_w[bus.s_sel] || bus.m_ready[bus.s_sel]);
  assign accept    = bus.s_valid && s_ready_w;

  for (genvar i = 0; i < NUM_OUT; i++) begin : g_slot
    logic load;

    assign load = accept && (bus.s_sel == SEL_W'(i));

    demux_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk   (clk),
      .rst   (rst),
      .load  (load),
      .din   (bus.s_data),
      .ready (bus.m_ready[i]),
      .valid (m_valid_w[i]),
      .dout  (m_data_w[i*DATA_W +: DATA_W])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_cnt <= '0;
    end else if (accept) begin
      acc_cnt <= acc_cnt + CNT_W'(1);
    end
  end

  assign bus.s_ready = s_ready_w;
  assign bus.m_valid = m_valid_w;
  assign bus.m_data  = m_data_w;

endmodule

// File: tb/tb_demux_1_4_stream.sv
// Directed bench for demux_1_4_stream: stimulus pushes expected words per sink,
// a monitor pops and compares them whenever a sink drains.
module tb_demux_1_4_stream;
  import demux_1_4_stream_pkg::*;

  logic        clk;
  logic        rst;
  logic [15:0] acc_cnt;

  int errors = 0;
  int checks = 0;

  logic [7:0] expq [4][$];

  demux_1_4_stream_if #(.DATA_W(8), .SEL_W(2)) bus ();

  demux_1_4_stream #(
    .DATA_W (8),
    .SEL_W  (2),
    .CNT_W  (16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .acc_cnt (acc_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Holds the word on the bus until accepted (or maxWait cycles pass), then
  // returns just after the accepting edge.
  task automatic applyStimulus(input logic [7:0] d, input logic [1:0] sel,
                               input int maxWait, output int waited);
    bit done;
    done = 0;
    waited = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_sel   = sel;
    while (!done) begin
      @(negedge clk);
      if (bus.s_ready === 1'b1) begin
        expq[sel].push_back(d);
        done = 1;
      end else if (waited >= maxWait) begin
        checks++;
        errors++;
        $display("[TB] FAIL accept_timeout: word 0x%0h sel %0d not accepted after %0d cycles", d, sel, waited);
        done = 1;
      end else begin
        waited++;
      end
      @(posedge clk);
      #1;
    end
    bus.s_valid = 1'b0;
  endtask

  // Scoreboard monitor: a word leaves a slot on the edge after valid&ready is seen.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.m_valid[i] === 1'b1 && bus.m_ready[i] === 1'b1) begin
          if (expq[i].size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL sink%0d_unexpected: got 0x%0h, expected no word", i, bus.m_data[i*8 +: 8]);
          end else begin
            checkOutput($sformatf("sink%0d_data", i), 32'(bus.m_data[i*8 +: 8]), 32'(expq[i].pop_front()));
          end
        end
      end
    end
  end

  initial begin
    int  w;
    int  accepted;
    int  bubbles;
    int  cycles;
    bit  hitMax;

    rst         = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'hEE;
    bus.s_sel   = 2'd1;
    bus.m_ready = 4'b0000;

    // Reset with a pending source word: nothing may be accepted.
    @(negedge clk);
    checkOutput("reset_s_ready", 32'(bus.s_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("reset_s_ready2", 32'(bus.s_ready), 32'd0);
    checkOutput("reset_m_valid", 32'(bus.m_valid), 32'd0);
    checkOutput("reset_m_data", bus.m_data, 32'd0);
    checkOutput("reset_acc_cnt", 32'(acc_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.s_valid = 1'b0;

    // Routing, back to back, all sinks ready.
    bus.m_ready = 4'b1111;
    applyStimulus(8'h11, 2'd0, 4, w);
    checkOutput("route0_m_valid", 32'(bus.m_valid), 32'b0001);
    checkOutput("route0_m_data", 32'(bus.m_data[7:0]), 32'h11);
    applyStimulus(8'h22, 2'd1, 4, w);
    checkOutput("route1_m_valid", 32'(bus.m_valid), 32'b0010);
    checkOutput("route1_m_data", 32'(bus.m_data[15:8]), 32'h22);
    applyStimulus(8'h33, 2'd2, 4, w);
    checkOutput("route2_m_valid", 32'(bus.m_valid), 32'b0100);
    applyStimulus(8'h44, 2'd3, 4, w);
    checkOutput("route3_m_valid", 32'(bus.m_valid), 32'b1000);
    checkOutput("route3_m_data", 32'(bus.m_data[31:24]), 32'h44);
    checkOutput("route_acc_cnt", 32'(acc_cnt), 32'd4);
    @(posedge clk);
    #1;
    checkOutput("route_drained", 32'(bus.m_valid), 32'd0);

    // Stall on sink 2, independence of sink 0.
    bus.m_ready = 4'b1011;
    applyStimulus(8'hA5, 2'd2, 4, w);
    checkOutput("stall_a5_loaded", 32'(bus.m_valid[2]), 32'd1);
    applyStimulus(8'h77, 2'(SINK_TAPE), 4, w);
    checkOutput("indep_no_wait", 32'(w), 32'd0);
    checkOutput("indep_m_valid", 32'(bus.m_valid), 32'b0101);
    checkOutput("indep_sink0", 32'(bus.m_data[7:0]), 32'h77);
    checkOutput("indep_sink2", 32'(bus.m_data[23:16]), 32'hA5);

    bus.s_valid = 1'b1;
    bus.s_data  = 8'h5A;
    bus.s_sel   = 2'd2;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("stall_s_ready_%0d", k), 32'(bus.s_ready), 32'd0);
      checkOutput($sformatf("stall_hold_%0d", k), 32'(bus.m_data[23:16]), 32'hA5);
    end
    @(posedge clk);
    #1;
    bus.m_ready = 4'b1111;
    applyStimulus(8'h5A, 2'd2, 2, w);
    checkOutput("reload_no_wait", 32'(w), 32'd0);
    checkOutput("reload_m_valid2", 32'(bus.m_valid[2]), 32'd1);
    checkOutput("reload_m_data2", 32'(bus.m_data[23:16]), 32'h5A);
    checkOutput("reload_acc_cnt", 32'(acc_cnt), 32'd7);
    @(posedge clk);
    #1;
    checkOutput("reload_drained", 32'(bus.m_valid), 32'd0);
    checkOutput("hold_after_drain", 32'(bus.m_data[23:16]), 32'h5A);

    // Reset mid-operation with two held words.
    bus.m_ready = 4'b0000;
    applyStimulus(8'h31, 2'(SINK_OUT), 4, w);
    applyStimulus(8'h93, 2'(SINK_AUX1), 4, w);
    checkOutput("midrst_pre_m_valid", 32'(bus.m_valid), 32'b1010);
    checkOutput("midrst_pre_acc_cnt", 32'(acc_cnt), 32'd9);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_s_ready", 32'(bus.s_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    expq[1].delete();
    expq[3].delete();
    checkOutput("midrst_m_valid", 32'(bus.m_valid), 32'd0);
    checkOutput("midrst_m_data", bus.m_data, 32'd0);
    checkOutput("midrst_acc_cnt", 32'(acc_cnt), 32'd0);

    // Counter wrap while streaming to the tape sink.
    bus.m_ready = 4'b1111;
    bus.s_sel   = 2'(SINK_TAPE);
    bus.s_valid = 1'b1;
    accepted = 0;
    bubbles  = 0;
    cycles   = 0;
    while (accepted < 65536 && cycles < 70000) begin
      hitMax = 0;
      bus.s_data = accepted[7:0];
      @(negedge clk);
      if (bus.s_ready === 1'b1) begin
        expq[SINK_TAPE].push_back(bus.s_data);
        accepted++;
        hitMax = (accepted == 65535);
      end else begin
        bubbles++;
      end
      @(posedge clk);
      #1;
      cycles++;
      if (hitMax) checkOutput("wrap_acc_max", 32'(acc_cnt), 32'hFFFF);
    end
    bus.s_valid = 1'b0;
    checkOutput("wrap_accepted", 32'(accepted), 32'd65536);
    checkOutput("wrap_bubbles", 32'(bubbles), 32'd0);
    checkOutput("wrap_acc_cnt", 32'(acc_cnt), 32'd0);

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("sink%0d_leftover", i), 32'(expq[i].size()), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
